// File: rtl/cell_config_loader.sv
// Configuration loader for the logic-cell array: stages per-cell words in a shadow
// register, checks a trailing XOR checksum, then commits all words to cfg_out at once.
module cell_config_loader #(
  parameter int NUM_CELLS = 4,
  parameter int CFG_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       in_valid,
  input  logic [CFG_W-1:0]           in_data,
  output logic                       in_ready,
  output logic [NUM_CELLS*CFG_W-1:0] cfg_out,
  output logic                       cfg_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam int IDX_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CELLS - 1);
  localparam logic [CFG_W-1:0] SEED     = {(CFG_W/2){2'b10}};

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_CSUM = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  logic [2:0]                 state_q,     state_d;
  logic [IDX_W-1:0]           index_q,     index_d;
  logic [CFG_W-1:0]           acc_q,       acc_d;
  logic [NUM_CELLS*CFG_W-1:0] shadow_q,    shadow_d;
  logic [NUM_CELLS*CFG_W-1:0] cfg_q,       cfg_d;
  logic                       cfg_valid_q, cfg_valid_d;
  logic                       done_q,      done_d;
  logic                       error_q,     error_d;
  logic                       beat_s;

  // abort masks in_ready so a word offered alongside abort is never consumed
  assign busy     = (state_q == ST_LOAD) || (state_q == ST_CSUM);
  assign in_ready = busy && !abort;
  assign beat_s   = in_valid && in_ready;

  assign cfg_out   = cfg_q;
  assign cfg_valid = cfg_valid_q;
  assign done      = done_q;
  assign error     = error_q;

  // Next-state and datapath decode for the load sequence
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    acc_d       = acc_q;
    shadow_d    = shadow_q;
    cfg_d       = cfg_q;
    cfg_valid_d = cfg_valid_q;
    done_d      = 1'b0;
    error_d     = error_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_LOAD;
          index_d = {IDX_W{1'b0}};
          acc_d   = SEED;
          error_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (beat_s) begin
          shadow_d[index_q*CFG_W +: CFG_W] = in_data;
          acc_d   = acc_q ^ in_data;
          index_d = index_q + IDX_W'(1);
          if (index_q == LAST_IDX) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_CSUM: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (beat_s) begin
          if (in_data == acc_q) begin
            cfg_d       = shadow_q;
            cfg_valid_d = 1'b1;
            done_d      = 1'b1;
            state_d     = ST_DONE;
          end else begin
            error_d = 1'b1;
            state_d = ST_ERR;
          end
        end else begin
          state_d = ST_CSUM;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (abort) begin
          error_d = 1'b0;
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_LOAD;
          index_d = {IDX_W{1'b0}};
          acc_d   = SEED;
          error_d = 1'b0;
        end else begin
          state_d = ST_ERR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      index_q     <= {IDX_W{1'b0}};
      acc_q       <= {CFG_W{1'b0}};
      shadow_q    <= {(NUM_CELLS*CFG_W){1'b0}};
      cfg_q       <= {(NUM_CELLS*CFG_W){1'b0}};
      cfg_valid_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      acc_q       <= acc_d;
      shadow_q    <= shadow_d;
      cfg_q       <= cfg_d;
      cfg_valid_q <= cfg_valid_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: tb/tb_cell_config_loader.sv
// Randomised scoreboard bench for cell_config_loader: a transaction-level model predicts
// each commit/error outcome, and a monitor compares whenever done or a new error appears.
module tb_cell_config_loader;

  localparam int NC = 4;
  localparam int CW = 8;
  localparam logic [7:0] SEED = 8'hAA;

  logic          clk, rst, start, abort, in_valid;
  logic [CW-1:0] in_data;
  logic          in_ready, cfg_valid, busy, done, error;
  logic [NC*CW-1:0] cfg_out;

  cell_config_loader #(.NUM_CELLS(NC), .CFG_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cfg_out(cfg_out), .cfg_valid(cfg_valid), .busy(busy),
    .done(done), .error(error)
  );

  typedef struct packed {
    logic        good;
    logic [31:0] cfg;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  logic [31:0] model_cfg = 32'h0;
  logic        model_valid = 1'b0;
  logic        model_err = 1'b0;
  logic        rdy_s;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus, driven on the falling edge; in_ready captured once settled
  task automatic cyc(input logic v, input logic [7:0] d, input logic s, input logic a);
    @(negedge clk);
    in_valid = v; in_data = d; start = s; abort = a;
    #1;
    rdy_s = in_ready;
  endtask

  task automatic send_word(input logic [7:0] d, input int gapmax, input bit noisy);
    bit ok;
    int gaps;
    ok = 1'b0;
    gaps = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
    repeat (gaps) cyc(1'b0, 8'($urandom), noisy && ($urandom_range(0, 1) == 1), 1'b0);
    for (int t = 0; t < 20; t++) begin
      cyc(1'b1, d, 1'b0, 1'b0);
      if (rdy_s) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout actual=in_ready_low required=accept_within_20");
    end
  endtask

  // Reference: checksum is SEED xor all words; a match commits words little-endian by cell
  task automatic predict(input logic [31:0] words, input logic [7:0] cs);
    logic [7:0] x;
    exp_t e;
    x = SEED;
    for (int i = 0; i < NC; i++) x = x ^ words[i*8 +: 8];
    if (cs == x) begin
      model_cfg = words;
      model_valid = 1'b1;
      model_err = 1'b0;
    end else begin
      model_err = 1'b1;
    end
    e.good = (cs == x);
    e.cfg = model_cfg;
    e.valid = model_valid;
    exp_q.push_back(e);
  endtask

  task automatic do_load(input logic [31:0] words, input logic [7:0] cs, input int gapmax, input bit noisy);
    cyc(1'b0, 8'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < NC; i++) send_word(words[i*8 +: 8], gapmax, noisy);
    predict(words, cs);
    send_word(cs, gapmax, noisy);
    cyc(1'b0, 8'($urandom), 1'b0, 1'b0);
    cyc(1'b0, 8'($urandom), 1'b0, 1'b0);
  endtask

  function automatic logic [7:0] csum_of(input logic [31:0] w);
    return SEED ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

  // Monitor: every done pulse or fresh error must match the oldest predicted outcome
  initial begin
    exp_t e;
    logic prev_err;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_err = 1'b0;
      end else begin
        if (done || (error && !prev_err)) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event actual=done%0b_error%0b required=none", done, error);
          end else begin
            e = exp_q.pop_front();
            chk("sb_done", 64'(done), 64'(e.good));
            chk("sb_error", 64'(error), 64'(!e.good));
            chk("sb_cfg_out", 64'(cfg_out), 64'(e.cfg));
            chk("sb_cfg_valid", 64'(cfg_valid), 64'(e.valid));
          end
        end
        prev_err = error;
      end
    end
  end

  initial begin
    logic [31:0] w;
    logic [7:0]  cs;
    rst = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #3;
    chk("rst_cfg_out", 64'(cfg_out), 64'h0);
    chk("rst_cfg_valid", 64'(cfg_valid), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_error", 64'(error), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    @(negedge clk);
    rst = 1'b1;

    // good load, then in_ready visible the cycle after start
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("start_in_ready", 64'(rdy_s), 64'h1);
    chk("start_busy", 64'(busy), 64'h1);
    for (int i = 0; i < NC; i++) send_word(8'h12 + 8'(i) * 8'h22, 0, 1'b0);
    predict(32'h78563412, 8'hA2);
    send_word(8'hA2, 0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("good_cfg_out", 64'(cfg_out), 64'h78563412);

    // bad checksum keeps previous configuration; error is sticky
    do_load(32'h04030201, 8'h00, 0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("bad_error_sticky", 64'(error), 64'h1);
    chk("bad_cfg_out_kept", 64'(cfg_out), 64'h78563412);

    // backpressure with random gaps and start noise, starting from the error state
    do_load(32'h78563412, 8'hA2, 3, 1'b1);
    chk("bp_error_cleared", 64'(error), 64'h0);

    // abort with a word offered: not accepted, back to idle, configuration unchanged
    model_cfg = 32'h78563412;
    do_load(32'hDDCCBBAA, csum_of(32'hDDCCBBAA), 1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    send_word(8'h99, 0, 1'b0);
    send_word(8'h98, 0, 1'b0);
    cyc(1'b1, 8'h55, 1'b0, 1'b1);
    chk("abort_in_ready", 64'(rdy_s), 64'h0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_cfg_out", 64'(cfg_out), 64'(model_cfg));
    do_load(32'h78563412, 8'hA2, 0, 1'b0);

    // simultaneous start and abort in idle: stays idle
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("start_abort_busy", 64'(busy), 64'h0);
    chk("start_abort_in_ready", 64'(rdy_s), 64'h0);

    // abort in error state clears the flag
    do_load(32'h11111111, 8'h01, 0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    model_err = 1'b0;
    chk("err_abort_error", 64'(error), 64'(model_err));
    chk("err_abort_busy", 64'(busy), 64'h0);

    // asynchronous reset after three words
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send_word(8'($urandom), 0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    model_cfg = 32'h0; model_valid = 1'b0; model_err = 1'b0;
    chk("midrst_cfg_out", 64'(cfg_out), 64'(model_cfg));
    chk("midrst_cfg_valid", 64'(cfg_valid), 64'(model_valid));
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_in_ready", 64'(in_ready), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    do_load(32'h78563412, 8'hA2, 0, 1'b0);

    // randomised loads, roughly half with a corrupted checksum
    for (int n = 0; n < 16; n++) begin
      w = $urandom;
      cs = csum_of(w);
      if ($urandom_range(0, 1) == 1) cs = cs ^ 8'($urandom_range(1, 255));
      do_load(w, cs, 3, 1'b1);
    end

    for (int t = 0; t < 20; t++) begin
      if (exp_q.size() == 0) break;
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    chk("final_cfg_out", 64'(cfg_out), 64'(model_cfg));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
